// File: rtl/piso_shift_register_if.sv
// rtl/piso_shift_register_if.sv - word handshake, bit strobe and serial-side bundle for the PISO shifter
// The master drives the word and the bit-rate strobe; the slave returns the serial stream and frame markers.
interface piso_shift_register_if #(
   parameter int DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] s_data;
   logic                  s_valid;
   logic                  s_ready;
   logic                  shift_en;
   logic                  sout;
   logic                  sout_valid;
   logic                  frame_start;
   logic                  frame_end;
   logic                  busy;

   modport master (
      output s_data, s_valid, shift_en,
      input  s_ready, sout, sout_valid, frame_start, frame_end, busy
   );

   modport slave (
      input  s_data, s_valid, shift_en,
      output s_ready, sout, sout_valid, frame_start, frame_end, busy
   );
endinterface

// File: rtl/piso_shift_register.sv
// rtl/piso_shift_register.sv - parallel-in serial-out shifter with frame markers and gapless reload
// A word accepted in IDLE, or on the last-bit strobe, appears on sout one clock later.
module piso_shift_register #(
   parameter int   DATA_WIDTH = 8,
   parameter int   MSB_FIRST  = 1,
   parameter logic IDLE_BIT   = 1'b1
) (
   input logic                  clk,
   input logic                  rst,
   piso_shift_register_if.slave bus
);
   localparam int CW = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(DATA_WIDTH - 1);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   state_t                r_state;
   logic [DATA_WIDTH-1:0] r_shreg;
   logic [CW-1:0]         r_bit_cnt;
   logic                  r_sout;

   logic                  w_busy;
   logic                  w_last;
   logic                  w_ready;
   logic                  w_xfer;
   logic                  w_load_bit;
   logic                  w_next_bit;
   logic [DATA_WIDTH-1:0] w_shifted;

   assign w_busy  = (r_state == ST_SHIFT);
   assign w_last  = w_busy && (r_bit_cnt == LAST_CNT);
   assign w_ready = !rst && ((r_state == ST_IDLE) || (w_last && bus.shift_en));
   assign w_xfer  = bus.s_valid && w_ready;

   // w_next_bit is the bit that reaches the output end after one zero-filled shift.
   always_comb begin
      if (MSB_FIRST != 0) begin
         w_shifted  = {r_shreg[DATA_WIDTH-2:0], 1'b0};
         w_load_bit = bus.s_data[DATA_WIDTH-1];
         w_next_bit = r_shreg[DATA_WIDTH-2];
      end else begin
         w_shifted  = {1'b0, r_shreg[DATA_WIDTH-1:1]};
         w_load_bit = bus.s_data[0];
         w_next_bit = r_shreg[1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_shreg   <= '0;
         r_bit_cnt <= '0;
         r_sout    <= IDLE_BIT;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_xfer) begin
                  r_state   <= ST_SHIFT;
                  r_shreg   <= bus.s_data;
                  r_bit_cnt <= '0;
                  r_sout    <= w_load_bit;
               end
            end
            ST_SHIFT: begin
               if (bus.shift_en) begin
                  if (!w_last) begin
                     r_shreg   <= w_shifted;
                     r_bit_cnt <= r_bit_cnt + 1'b1;
                     r_sout    <= w_next_bit;
                  end else if (w_xfer) begin
                     // Reload on the last-bit strobe keeps the stream gapless.
                     r_shreg   <= bus.s_data;
                     r_bit_cnt <= '0;
                     r_sout    <= w_load_bit;
                  end else begin
                     r_state   <= ST_IDLE;
                     r_sout    <= IDLE_BIT;
                  end
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_sout  <= IDLE_BIT;
            end
         endcase
      end
   end

   assign bus.s_ready     = w_ready;
   assign bus.sout        = r_sout;
   assign bus.sout_valid  = w_busy;
   assign bus.busy        = w_busy;
   assign bus.frame_start = w_busy && (r_bit_cnt == '0);
   assign bus.frame_end   = w_last;
endmodule

// File: tb/tb_piso_shift_register.sv
// tb/tb_piso_shift_register.sv - directed bench for piso_shift_register, MSB-first and LSB-first instances
// Inputs change and outputs are sampled on the falling edge; the DUT acts on the rising edge.
module tb_piso_shift_register;
   logic clk;
   logic rst;
   int   n_checks;
   int   n_fails;

   piso_shift_register_if #(.DATA_WIDTH(8)) bm ();
   piso_shift_register_if #(.DATA_WIDTH(8)) bl ();

   piso_shift_register #(.DATA_WIDTH(8), .MSB_FIRST(1), .IDLE_BIT(1'b1)) u_msb (
      .clk (clk),
      .rst (rst),
      .bus (bm)
   );

   piso_shift_register #(.DATA_WIDTH(8), .MSB_FIRST(0), .IDLE_BIT(1'b1)) u_lsb (
      .clk (clk),
      .rst (rst),
      .bus (bl)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_bit(input string tag, input logic got, input logic exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s got=%b exp=%b t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic check_idle_msb(input string tag);
      check_bit({tag, "_sout"},  bm.sout,       1'b1);
      check_bit({tag, "_valid"}, bm.sout_valid, 1'b0);
      check_bit({tag, "_busy"},  bm.busy,       1'b0);
      check_bit({tag, "_fs"},    bm.frame_start, 1'b0);
      check_bit({tag, "_fe"},    bm.frame_end,  1'b0);
   endtask

   logic [7:0]  word;
   logic [15:0] stream;

   initial begin
      n_checks = 0;
      n_fails  = 0;
      rst = 1'b1;
      bm.s_data = 8'h00; bm.s_valid = 1'b0; bm.shift_en = 1'b0;
      bl.s_data = 8'h00; bl.s_valid = 1'b0; bl.shift_en = 1'b0;
      tick(); tick();

      // reset state, with s_valid asserted to show s_ready is held low
      bm.s_valid = 1'b1; bm.s_data = 8'hFF;
      #1;
      check_idle_msb("rst");
      check_bit("rst_ready", bm.s_ready, 1'b0);
      tick();
      check_idle_msb("rst_hold");
      bm.s_valid = 1'b0;
      rst = 1'b0;
      #1;
      check_bit("idle_ready", bm.s_ready, 1'b1);

      // single word 0xA5, MSB first
      word = 8'hA5;
      bm.s_data = word; bm.s_valid = 1'b1; bm.shift_en = 1'b1;
      tick();
      bm.s_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         #1;
         check_bit("single_sout",  bm.sout,        word[7-i]);
         check_bit("single_valid", bm.sout_valid,  1'b1);
         check_bit("single_fs",    bm.frame_start, (i == 0));
         check_bit("single_fe",    bm.frame_end,   (i == 7));
         tick();
      end
      #1;
      check_idle_msb("single_end");

      // back-to-back 0xA5, 0x3C with s_valid held
      stream = 16'hA53C;
      bm.s_data = 8'hA5; bm.s_valid = 1'b1; bm.shift_en = 1'b1;
      #1;
      check_bit("b2b_ready0", bm.s_ready, 1'b1);
      tick();
      bm.s_data = 8'h3C;
      for (int i = 0; i < 16; i++) begin
         if (i == 8) bm.s_valid = 1'b0;
         #1;
         check_bit("b2b_sout",  bm.sout,       stream[15-i]);
         check_bit("b2b_valid", bm.sout_valid, 1'b1);
         check_bit("b2b_ready", bm.s_ready,    (i == 7) || (i == 15));
         check_bit("b2b_fs",    bm.frame_start, (i == 0) || (i == 8));
         tick();
      end
      #1;
      check_idle_msb("b2b_end");

      // slow rate: strobe every third cycle, word 0xF0
      word = 8'hF0;
      bm.s_data = word; bm.s_valid = 1'b1; bm.shift_en = 1'b0;
      tick();
      bm.s_valid = 1'b0;
      for (int c = 0; c < 24; c++) begin
         bm.shift_en = ((c % 3) == 2);
         #1;
         check_bit("slow_sout",  bm.sout,       word[7 - (c / 3)]);
         check_bit("slow_valid", bm.sout_valid, 1'b1);
         check_bit("slow_busy",  bm.busy,       1'b1);
         tick();
      end
      bm.shift_en = 1'b1;
      #1;
      check_idle_msb("slow_end");

      // LSB first, 0x01
      word = 8'h01;
      bl.s_data = word; bl.s_valid = 1'b1; bl.shift_en = 1'b1;
      tick();
      bl.s_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         #1;
         check_bit("lsb_sout", bl.sout,        word[i]);
         check_bit("lsb_fs",   bl.frame_start, (i == 0));
         check_bit("lsb_fe",   bl.frame_end,   (i == 7));
         tick();
      end
      #1;
      check_bit("lsb_end_sout",  bl.sout,       1'b1);
      check_bit("lsb_end_valid", bl.sout_valid, 1'b0);

      // backpressure: 0x55 offered while bit 3 of 0xA5 is on sout
      stream = 16'hA555;
      bm.s_data = 8'hA5; bm.s_valid = 1'b1; bm.shift_en = 1'b1;
      tick();
      bm.s_valid = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (i == 2) begin
            bm.s_data  = 8'h55;
            bm.s_valid = 1'b1;
         end
         if (i == 8) bm.s_valid = 1'b0;
         #1;
         check_bit("bp_sout",  bm.sout,    stream[15-i]);
         check_bit("bp_ready", bm.s_ready, (i == 7) || (i == 15));
         check_bit("bp_fe",    bm.frame_end, (i == 7) || (i == 15));
         tick();
      end
      #1;
      check_idle_msb("bp_end");

      // reset while bit 4 of 0xA5 is on sout, then 0x81 from its first bit
      word = 8'hA5;
      bm.s_data = word; bm.s_valid = 1'b1; bm.shift_en = 1'b1;
      tick();
      bm.s_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         check_bit("mid_sout", bm.sout, word[7-i]);
         tick();
      end
      rst = 1'b1;
      bm.s_data = 8'h81; bm.s_valid = 1'b1;
      #1;
      check_bit("mid_bit4",  bm.sout,    word[4]);
      check_bit("mid_ready", bm.s_ready, 1'b0);
      tick();
      #1;
      check_idle_msb("mid_rst");
      check_bit("mid_rst_ready", bm.s_ready, 1'b0);
      rst = 1'b0;
      #1;
      check_bit("mid_ready_after", bm.s_ready, 1'b1);
      word = 8'h81;
      tick();
      bm.s_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         #1;
         check_bit("post_sout", bm.sout,        word[7-i]);
         check_bit("post_fs",   bm.frame_start, (i == 0));
         check_bit("post_fe",   bm.frame_end,   (i == 7));
         tick();
      end
      #1;
      check_idle_msb("post_end");

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
      $finish;
   end
endmodule
